// File: rtl/ex_muldiv_unit_pkg.sv
// Shared encodings for the execute-stage multiply/divide unit: op codes,
// FSM states and small op-decode helpers.
package ex_muldiv_unit_pkg;

  typedef enum logic [1:0] {
    MD_MULT  = 2'd0,
    MD_MULTU = 2'd1,
    MD_DIV   = 2'd2,
    MD_DIVU  = 2'd3
  } md_op_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FIXUP = 2'd2
  } md_state_e;

  function automatic logic is_div_op(input md_op_e op);
    return (op == MD_DIV) || (op == MD_DIVU);
  endfunction

  function automatic logic is_signed_op(input md_op_e op);
    return (op == MD_MULT) || (op == MD_DIV);
  endfunction

endpackage

// File: rtl/ex_muldiv_unit_if.sv
// ID/EX-side bundle for the multiply/divide unit: issue and MT/MF controls
// in, HI/LO and status out.
interface ex_muldiv_unit_if #(
  parameter int DATA_W = 32
);
  logic              start;
  logic [1:0]        op;
  logic [DATA_W-1:0] rs_val;
  logic [DATA_W-1:0] rt_val;
  logic              mthi;
  logic              mtlo;
  logic              rd_hilo;
  logic [DATA_W-1:0] hi;
  logic [DATA_W-1:0] lo;
  logic              busy;
  logic              stall_req;
  logic              done;
  logic              div_zero;

  modport master (
    output start, op, rs_val, rt_val, mthi, mtlo, rd_hilo,
    input  hi, lo, busy, stall_req, done, div_zero
  );

  modport slave (
    input  start, op, rs_val, rt_val, mthi, mtlo, rd_hilo,
    output hi, lo, busy, stall_req, done, div_zero
  );
endinterface

// File: rtl/ex_muldiv_unit_step.sv
// One radix-2 iteration on the 2*DATA_W+1 accumulator: shift-add for
// multiply, restoring shift-subtract for divide.
module muldiv_step #(
  parameter int DATA_W = 32
) (
  input  logic              is_div,
  input  logic [2*DATA_W:0] acc,
  input  logic [DATA_W-1:0] operand,
  output logic [2*DATA_W:0] acc_next
);
  logic [DATA_W-1:0] addend;
  logic [DATA_W:0]   sum;
  logic [DATA_W:0]   shifted_rem;
  logic [DATA_W+1:0] diff;
  logic              borrow;

  // Multiply: add the multiplicand into the upper half when the LSB is set,
  // then shift right; the top bit catches the carry of that add.
  assign addend = acc[0] ? operand : {DATA_W{1'b0}};
  assign sum    = acc[2*DATA_W:DATA_W] + {1'b0, addend};

  // Divide: bring the next dividend bit into the remainder and trial-subtract.
  assign shifted_rem = acc[2*DATA_W-1:DATA_W-1];
  assign diff        = {1'b0, shifted_rem} - {2'b00, operand};
  assign borrow      = diff[DATA_W+1];

  always_comb begin
    acc_next = '0;
    if (!is_div) begin
      acc_next = {1'b0, sum, acc[DATA_W-1:1]};
    end else if (!borrow) begin
      acc_next = {diff[DATA_W:0], acc[DATA_W-2:0], 1'b1};
    end else begin
      acc_next = {shifted_rem, acc[DATA_W-2:0], 1'b0};
    end
  end
endmodule

// File: rtl/ex_muldiv_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit with HI/LO registers and stall request.
// Define MULDIV_FAST_MULT_EN for single-cycle multiplies; divides stay iterative.
module ex_muldiv_unit
  import ex_muldiv_unit_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input logic             clk,
  input logic             reset,
  ex_muldiv_unit_if.slave bus
);
  localparam int CNT_W = $clog2(DATA_W);
  localparam int ACC_W = 2 * DATA_W + 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(DATA_W - 1);

  md_state_e         state, state_next;
  logic [CNT_W-1:0]  count;
  logic [ACC_W-1:0]  acc, acc_step, acc_load;
  logic [DATA_W-1:0] operand, hi_q, lo_q;
  logic              div_q, neg_res, neg_rem, zero_div, done_q, div_zero_q;

  md_op_e            op_in;
  logic              signed_in, div_in, fast_mul;
  logic [DATA_W-1:0] abs_rs, abs_rt;

  assign op_in     = md_op_e'(bus.op);
  assign signed_in = is_signed_op(op_in);
  assign div_in    = is_div_op(op_in);
  // -(2^(W-1)) wraps to itself, which read as unsigned is the wanted magnitude.
  assign abs_rs = (signed_in && bus.rs_val[DATA_W-1]) ? -bus.rs_val : bus.rs_val;
  assign abs_rt = (signed_in && bus.rt_val[DATA_W-1]) ? -bus.rt_val : bus.rt_val;

`ifdef MULDIV_FAST_MULT_EN
  logic [2*DATA_W-1:0] fast_prod;
  assign fast_prod = (2*DATA_W)'(abs_rs) * (2*DATA_W)'(abs_rt);
  assign fast_mul  = !div_in;
  assign acc_load  = fast_mul ? {1'b0, fast_prod} : {{(DATA_W+1){1'b0}}, abs_rs};
`else
  assign fast_mul  = 1'b0;
  assign acc_load  = {{(DATA_W+1){1'b0}}, abs_rs};
`endif

  muldiv_step #(.DATA_W(DATA_W)) u_step (
    .is_div   (div_q),
    .acc      (acc),
    .operand  (operand),
    .acc_next (acc_step)
  );

  logic [2*DATA_W-1:0] prod_mag, prod_fix;
  logic [DATA_W-1:0]   quot_fix, rem_fix;

  assign prod_mag = acc[2*DATA_W-1:0];
  assign prod_fix = neg_res ? -prod_mag : prod_mag;
  assign quot_fix = zero_div ? {DATA_W{1'b1}}
                  : (neg_res ? -acc[DATA_W-1:0] : acc[DATA_W-1:0]);
  assign rem_fix  = neg_rem ? -acc[2*DATA_W-1:DATA_W] : acc[2*DATA_W-1:DATA_W];

  always_ff @(posedge clk) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:  if (bus.start) state_next = fast_mul ? ST_FIXUP : ST_RUN;
      ST_RUN:   if (count == LAST) state_next = ST_FIXUP;
      ST_FIXUP: state_next = ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
  end

  // Operands and MT writes are only accepted in IDLE; HI/LO change only at FIXUP.
  always_ff @(posedge clk) begin
    if (reset) begin
      count      <= '0;
      acc        <= '0;
      operand    <= '0;
      hi_q       <= '0;
      lo_q       <= '0;
      div_q      <= 1'b0;
      neg_res    <= 1'b0;
      neg_rem    <= 1'b0;
      zero_div   <= 1'b0;
      done_q     <= 1'b0;
      div_zero_q <= 1'b0;
    end else begin
      done_q     <= 1'b0;
      div_zero_q <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (bus.start) begin
            acc      <= acc_load;
            operand  <= abs_rt;
            count    <= '0;
            div_q    <= div_in;
            neg_res  <= signed_in & (bus.rs_val[DATA_W-1] ^ bus.rt_val[DATA_W-1]);
            neg_rem  <= signed_in & bus.rs_val[DATA_W-1];
            zero_div <= div_in && (bus.rt_val == '0);
          end else begin
            if (bus.mthi) hi_q <= bus.rs_val;
            if (bus.mtlo) lo_q <= bus.rs_val;
          end
        end
        ST_RUN: begin
          acc   <= acc_step;
          count <= count + 1'b1;
        end
        ST_FIXUP: begin
          if (div_q) begin
            hi_q <= rem_fix;
            lo_q <= quot_fix;
          end else begin
            hi_q <= prod_fix[2*DATA_W-1:DATA_W];
            lo_q <= prod_fix[DATA_W-1:0];
          end
          done_q     <= 1'b1;
          div_zero_q <= zero_div;
          count      <= '0;
        end
        default: ;
      endcase
    end
  end

  assign bus.hi        = hi_q;
  assign bus.lo        = lo_q;
  assign bus.busy      = (state != ST_IDLE);
  assign bus.stall_req = bus.busy & (bus.start | bus.rd_hilo | bus.mthi | bus.mtlo);
  assign bus.done      = done_q;
  assign bus.div_zero  = div_zero_q;
endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Self-checking bench for ex_muldiv_unit: directed corner cases plus randomized
// ops, checked against a plain-arithmetic HI/LO reference model.
module tb_ex_muldiv_unit;
  import ex_muldiv_unit_pkg::*;

  logic        clk;
  logic        reset;
  int          vectors = 0;
  int          miscompares = 0;
  logic [31:0] exp_hi, exp_lo;

  ex_muldiv_unit_if #(.DATA_W(32)) bus ();

  ex_muldiv_unit #(.DATA_W(32)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic check_output(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
    vectors++;
    assert (observed === expected) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  // Returns {div_zero, hi, lo} computed directly from the arithmetic definition.
  function automatic logic [64:0] ref_model(input logic [1:0] op, input logic [31:0] a,
                                            input logic [31:0] b);
    longint      sa, sb, sp;
    logic [63:0] up;
    int          q, r;
    case (op)
      MD_MULT: begin
        sa = int'(a);
        sb = int'(b);
        sp = sa * sb;
        return {1'b0, 64'(sp)};
      end
      MD_MULTU: begin
        up = 64'(a) * 64'(b);
        return {1'b0, up};
      end
      MD_DIV: begin
        if (b == 32'd0) return {1'b1, a, 32'hFFFFFFFF};
        if (a == 32'h80000000 && b == 32'hFFFFFFFF) return {1'b0, 32'h0, 32'h80000000};
        q = int'(a) / int'(b);
        r = int'(a) % int'(b);
        return {1'b0, 32'(r), 32'(q)};
      end
      default: begin
        if (b == 32'd0) return {1'b1, a, 32'hFFFFFFFF};
        return {1'b0, a % b, a / b};
      end
    endcase
  endfunction

  function automatic int exp_latency(input logic [1:0] op);
`ifdef MULDIV_FAST_MULT_EN
    if (op == MD_MULT || op == MD_MULTU) return 1;
`endif
    return (op == 2'd0) ? 33 : 33;
  endfunction

  // Issue one op, watch every busy cycle, then check result and pulses.
  task automatic apply_stimulus(input logic [1:0] op, input logic [31:0] a,
                                input logic [31:0] b, input int rdh_at,
                                input bit noise, input bit with_mthi);
    logic [64:0] r;
    int          cycles;
    logic        es;
    r = ref_model(op, a, b);
    bus.op     = op;
    bus.rs_val = a;
    bus.rt_val = b;
    bus.start  = 1'b1;
    bus.mthi   = with_mthi;
    #1;
    check_output("issue_busy", 32'(bus.busy), 32'd0);
    check_output("issue_stall", 32'(bus.stall_req), 32'd0);
    tick();
    bus.start = 1'b0;
    bus.mthi  = 1'b0;
    cycles = 0;
    while (bus.busy === 1'b1 && cycles < 100) begin
      if (noise) begin
        bus.rs_val = $urandom;
        bus.rt_val = $urandom;
        bus.start  = 1'($urandom_range(0, 1));
        bus.mthi   = 1'($urandom_range(0, 1));
        bus.mtlo   = 1'($urandom_range(0, 1));
      end
      bus.rd_hilo = (rdh_at >= 0 && cycles >= rdh_at);
      #1;
      es = bus.start | bus.rd_hilo | bus.mthi | bus.mtlo;
      check_output("busy_stall", 32'(bus.stall_req), 32'(es));
      check_output("hold_hi", bus.hi, exp_hi);
      check_output("hold_lo", bus.lo, exp_lo);
      check_output("busy_done", 32'(bus.done), 32'd0);
      tick();
      cycles++;
    end
    bus.start = 1'b0;
    bus.mthi  = 1'b0;
    bus.mtlo  = 1'b0;
    #1;
    check_output("idle_stall", 32'(bus.stall_req), 32'd0);
    bus.rd_hilo = 1'b0;
    check_output("busy_cycles", 32'(cycles), 32'(exp_latency(op)));
    exp_hi = r[63:32];
    exp_lo = r[31:0];
    check_output("result_hi", bus.hi, exp_hi);
    check_output("result_lo", bus.lo, exp_lo);
    check_output("done_pulse", 32'(bus.done), 32'd1);
    check_output("div_zero", 32'(bus.div_zero), 32'(r[64]));
    tick();
    check_output("done_clear", 32'(bus.done), 32'd0);
    check_output("div_zero_clear", 32'(bus.div_zero), 32'd0);
  endtask

  initial begin
    logic [1:0]  op;
    logic [31:0] a, b;
    reset       = 1'b1;
    bus.start   = 1'b0;
    bus.op      = 2'd0;
    bus.rs_val  = '0;
    bus.rt_val  = '0;
    bus.mthi    = 1'b0;
    bus.mtlo    = 1'b0;
    bus.rd_hilo = 1'b0;
    exp_hi      = '0;
    exp_lo      = '0;
    repeat (2) tick();
    reset = 1'b0;
    check_output("rst_hi", bus.hi, 32'd0);
    check_output("rst_lo", bus.lo, 32'd0);
    check_output("rst_busy", 32'(bus.busy), 32'd0);
    check_output("rst_done", 32'(bus.done), 32'd0);
    check_output("rst_div_zero", 32'(bus.div_zero), 32'd0);
    check_output("rst_stall", 32'(bus.stall_req), 32'd0);

    apply_stimulus(MD_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, -1, 1'b0, 1'b0);
    check_output("multu_max_hi", bus.hi, 32'hFFFFFFFE);
    check_output("multu_max_lo", bus.lo, 32'h00000001);
    apply_stimulus(MD_MULT, 32'hFFFFFFFD, 32'd7, 5, 1'b0, 1'b0);
    check_output("mult_neg_lo", bus.lo, 32'hFFFFFFEB);
    apply_stimulus(MD_DIV, 32'hFFFFFFF9, 32'd2, -1, 1'b0, 1'b1);
    check_output("div_neg_lo", bus.lo, 32'hFFFFFFFD);
    apply_stimulus(MD_DIVU, 32'd7, 32'd0, -1, 1'b0, 1'b0);
    apply_stimulus(MD_DIV, 32'h80000000, 32'hFFFFFFFF, -1, 1'b0, 1'b0);
    apply_stimulus(MD_DIV, 32'hFFFFFFF7, 32'd0, -1, 1'b0, 1'b0);
    apply_stimulus(MD_MULT, 32'h80000000, 32'h80000000, -1, 1'b0, 1'b0);
    apply_stimulus(MD_DIVU, 32'd100, 32'd7, 0, 1'b0, 1'b0);
    check_output("divu_100_7_lo", bus.lo, 32'd14);
    apply_stimulus(MD_MULTU, 32'h00010000, 32'h00010000, -1, 1'b0, 1'b0);

    bus.rs_val = 32'hCAFEF00D;
    bus.mthi   = 1'b1;
    #1;
    check_output("mthi_stall", 32'(bus.stall_req), 32'd0);
    tick();
    bus.mthi = 1'b0;
    exp_hi   = 32'hCAFEF00D;
    check_output("mthi_hi", bus.hi, exp_hi);
    check_output("mthi_lo", bus.lo, exp_lo);

    for (int i = 0; i < 12; i++) begin
      op = 2'($urandom_range(0, 3));
      a  = $urandom;
      b  = $urandom;
      if ($urandom_range(0, 3) == 0) b = 32'($urandom_range(0, 3));
      apply_stimulus(op, a, b, int'($urandom_range(0, 40)), 1'b1, 1'b0);
    end

    bus.op     = MD_MULT;
    bus.rs_val = 32'd12345;
    bus.rt_val = 32'd678;
    bus.start  = 1'b1;
    tick();
    bus.start = 1'b0;
    repeat (10) tick();
    check_output("mid_busy", 32'(bus.busy), 32'd1);
    reset = 1'b1;
    tick();
    reset  = 1'b0;
    exp_hi = '0;
    exp_lo = '0;
    check_output("midrst_busy", 32'(bus.busy), 32'd0);
    check_output("midrst_hi", bus.hi, exp_hi);
    check_output("midrst_lo", bus.lo, exp_lo);
    check_output("midrst_done", 32'(bus.done), 32'd0);
    bus.rs_val = 32'h00001234;
    bus.mtlo   = 1'b1;
    #1;
    check_output("mtlo_stall", 32'(bus.stall_req), 32'd0);
    tick();
    bus.mtlo = 1'b0;
    exp_lo   = 32'h00001234;
    check_output("mtlo_lo", bus.lo, exp_lo);
    check_output("mtlo_hi", bus.hi, exp_hi);
    check_output("mtlo_busy", 32'(bus.busy), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
